roteamento_rr: RTL and testbench
================================

# roteamento_rr

Parametrised N-channel, NBITS-wide router that selects one of NCH input channels and delivers the word through a one-entry registered output with valid/ready handshake. Selection is either fixed (`sel` chooses the channel) or round-robin arbitration among valid channels. It replaces the purely combinational 2:1 router wherever several producers share one consumer.

## Interface
- NBITS, 4, data width per channel (>=1)
- NCH, 4, number of input channels (>=2, need not be a power of two)
- CW, $clog2(NCH), channel-index width (derived, not overridden)

- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  NCH*NBITS  channel i occupies bits [i*NBITS +: NBITS]
- in_valid  input  NCH  channel i has a word
- in_ready  output  NCH  channel i's word is accepted this cycle
- modo  input  1  0 = fixed (MODO_FIXO), 1 = round-robin (MODO_RR)
- sel  input  CW  channel chosen in fixed mode
- out_data  output  NBITS  buffered word
- out_ch  output  CW  channel that supplied out_data
- out_valid  output  1  buffer holds a word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Buffer: one register set {out_data, out_ch, out_valid}.
- load_en = !out_valid | out_ready. When load_en, the buffer is written each cycle: with the granted word (out_valid=1) if a grant exists, else out_valid=0.
- Grant, fixed mode: channel `sel` if in_valid[sel]; no grant if sel >= NCH or in_valid[sel]=0.
- Grant, round-robin mode: first i with in_valid[i], searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1.
- in_ready[i] = load_en & grant[i]; at most one bit set. in_ready is combinational from in_valid, modo, sel, ptr, out_valid, out_ready.
- ptr (CW bits): on an accepted transfer in MODO_RR, ptr <= granted+1, wrapping NCH-1 -> 0 (explicit compare, not bit overflow). ptr is unchanged in MODO_FIXO and on cycles without a transfer.
- Producer may hold in_valid and data until in_ready; dropping in_valid before acceptance is allowed (no grant is latched).
- Consumer: out_data/out_ch stable while out_valid=1 and out_ready=0.

## Timing
- Reset (async assert, sync-to-clock release): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready therefore follows grant immediately after reset (buffer empty).
- Latency: word accepted at edge k appears on out_data in the cycle after edge k (1 cycle).
- Throughput: 1 word/cycle with out_ready held 1; simultaneous drain and load in the same cycle is required, no bubble.
- Backpressure: out_valid=1, out_ready=0 -> all in_ready=0, buffer held.
- modo/sel changes take effect on the next grant evaluation; buffered word unaffected.
- Reset mid-transfer: buffered word discarded, ptr returns to 0.

## Structure
- Package roteamento_pkg: typedef enum logic {MODO_FIXO, MODO_RR} modo_t; default NBITS/NCH localparams.
- Sub-module rr_arbiter (purely combinational): inputs req[NCH], ptr; outputs grant one-hot and grant index plus any-grant flag. Top-level holds ptr, buffer and fixed-mode mux.

## Test plan
- Reset mid-stream with out_valid=1 -> out_valid, out_data, out_ch, ptr go 0 immediately, without waiting for a clock edge.
- Fixed mode, NCH=4, sel=2, in_valid=4'b1111, in_data ch2=4'hA, out_ready=1 -> in_ready=4'b0100, next cycle out_data=4'hA, out_ch=2; sel=3 with in_valid[3]=0 -> no grant, out_valid=0.
- Round-robin, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Round-robin, in_valid=4'b1001 after grant of ch3 -> next grant ch0, then ch3 (wrap), ptr=0 after the ch3 grant.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while ch1 valid -> in_ready=0, out_data stable; out_ready=1 -> drain and ch1 loaded same cycle.
- NCH=3 (non-power-of-two), round-robin, all valid -> out_ch 0,1,2,0; sel=3 in fixed mode -> no grant.

Source files
------------

// File: rtl/roteamento_rr_pkg.sv
// Shared types and defaults for the roteamento_rr router.
package roteamento_pkg;

  typedef enum logic {
    MODO_FIXO = 1'b0,
    MODO_RR   = 1'b1
  } modo_t;

  localparam int unsigned NBITS_DEF = 4;
  localparam int unsigned NCH_DEF   = 4;

  // Modular add for channel indices when the channel count is not a power of two.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/roteamento_rr_if.sv
// Producer/consumer bundle of the router: NCH input channels, one buffered output.
interface roteamento_rr_if
  import roteamento_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned NCH   = NCH_DEF
) ();

  localparam int unsigned CW = $clog2(NCH);

  logic [NCH*NBITS-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  modo_t                modo;
  logic [CW-1:0]        sel;
  logic [NBITS-1:0]     out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, modo, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, modo, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/roteamento_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at NCH.
module rr_arbiter
  import roteamento_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  localparam int unsigned CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant,
  output logic [CW-1:0]  o_idx,
  output logic           o_any
);

  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned k = NCH; k > 0; k--) begin
      if (i_req[CW'(wrap_add(32'(i_ptr), k - 1, NCH))]) begin
        o_grant = '0;
        o_grant[CW'(wrap_add(32'(i_ptr), k - 1, NCH))] = 1'b1;
        o_idx   = CW'(wrap_add(32'(i_ptr), k - 1, NCH));
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/roteamento_rr.sv
// N-channel router with fixed or round-robin selection into a one-entry output buffer.
module roteamento_rr
  import roteamento_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned NCH   = NCH_DEF
) (
  input logic            clock,
  input logic            reset,
  roteamento_rr_if.slave bus
);

  localparam int unsigned CW   = $clog2(NCH);
  localparam int unsigned SELW = 1 << CW;

  logic [NBITS-1:0] r_data;
  logic [CW-1:0]    r_ch;
  logic [CW-1:0]    r_ptr;
  logic             r_valid;

  logic [NCH-1:0]   w_rr_grant;
  logic [CW-1:0]    w_rr_idx;
  logic             w_rr_any;
  logic [SELW-1:0]  w_valid_ext;
  logic             w_fix_any;
  logic [NCH-1:0]   w_fix_grant;
  logic [NCH-1:0]   w_grant;
  logic [CW-1:0]    w_idx;
  logic             w_any;
  logic             w_load;
  logic [NBITS-1:0] w_word;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req   (bus.in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // Zero-extend valids to the full sel range so out-of-range sel reads as no request.
  assign w_valid_ext = SELW'(bus.in_valid);
  assign w_fix_any   = w_valid_ext[bus.sel];
  assign w_fix_grant = w_fix_any ? (NCH'(1) << bus.sel) : '0;

  always_comb begin
    w_grant = w_fix_grant;
    w_idx   = bus.sel;
    w_any   = w_fix_any;
    if (bus.modo == MODO_RR) begin
      w_grant = w_rr_grant;
      w_idx   = w_rr_idx;
      w_any   = w_rr_any;
    end
  end

  // Buffer can take a word when empty or being drained this cycle.
  assign w_load       = !r_valid || bus.out_ready;
  assign bus.in_ready = {NCH{w_load}} & w_grant;

  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_grant[i]) w_word = w_word | bus.in_data[i*NBITS +: NBITS];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= w_word;
        r_ch   <= w_idx;
        if (bus.modo == MODO_RR) r_ptr <= CW'(wrap_add(32'(w_idx), 1, NCH));
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_roteamento_rr.sv
// Bench for roteamento_rr: NCH=4 and NCH=3 instances against a search-list reference model.
module tb_roteamento_rr;
  import roteamento_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  roteamento_rr_if #(.NBITS(4), .NCH(4)) bus4 ();
  roteamento_rr_if #(.NBITS(4), .NCH(3)) bus3 ();

  roteamento_rr #(.NBITS(4), .NCH(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
  roteamento_rr #(.NBITS(4), .NCH(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3.slave));

  int checks   = 0;
  int failures = 0;

  // Stimulus per instance (0: NCH=4, 1: NCH=3)
  logic [3:0]  t_valid [2];
  logic [15:0] t_data  [2];
  bit          t_rr    [2];
  int          t_sel   [2];
  bit          t_rdy   [2];

  assign bus4.in_valid  = t_valid[0];
  assign bus4.in_data   = t_data[0];
  assign bus4.modo      = modo_t'(t_rr[0]);
  assign bus4.sel       = 2'(t_sel[0]);
  assign bus4.out_ready = t_rdy[0];
  assign bus3.in_valid  = t_valid[1][2:0];
  assign bus3.in_data   = t_data[1][11:0];
  assign bus3.modo      = modo_t'(t_rr[1]);
  assign bus3.sel       = 2'(t_sel[1]);
  assign bus3.out_ready = t_rdy[1];

  // Reference model state
  bit m_valid [2];
  int m_data  [2];
  int m_ch    [2];
  int m_ptr   [2];

  function automatic int nch_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Granted channel per the selection rules, -1 when none.
  function automatic int grant_of(int d);
    int n;
    n = nch_of(d);
    if (!t_rr[d]) return (t_sel[d] < n && t_valid[d][t_sel[d]]) ? t_sel[d] : -1;
    for (int k = 0; k < n; k++) begin
      if (t_valid[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [31:0] obs(int d, int what);
    case (what)
      0:       return (d == 0) ? 32'(bus4.in_ready)  : 32'(bus3.in_ready);
      1:       return (d == 0) ? 32'(bus4.out_valid) : 32'(bus3.out_valid);
      2:       return (d == 0) ? 32'(bus4.out_data)  : 32'(bus3.out_data);
      3:       return (d == 0) ? 32'(bus4.out_ch)    : 32'(bus3.out_ch);
      default: return (d == 0) ? 32'(dut4.r_ptr)     : 32'(dut3.r_ptr);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = 0; m_ch[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic check_outputs(input string sfx);
    for (int d = 0; d < 2; d++) begin
      chk({"out_valid", sfx}, obs(d, 1), 32'(m_valid[d]));
      chk({"ptr", sfx}, obs(d, 4), 32'(m_ptr[d]));
      if (m_valid[d]) begin
        chk({"out_data", sfx}, obs(d, 2), 32'(m_data[d]));
        chk({"out_ch", sfx}, obs(d, 3), 32'(m_ch[d]));
      end
    end
  endtask

  // One clock: check in_ready, take the edge, advance the model, check the buffer.
  task automatic tick();
    int g  [2];
    bit le [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]  = grant_of(d);
      le[d] = !m_valid[d] || t_rdy[d];
      chk((d == 0) ? "in_ready4" : "in_ready3", obs(d, 0),
          (le[d] && g[d] >= 0) ? (32'd1 << g[d]) : 32'd0);
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (le[d]) begin
        m_valid[d] = (g[d] >= 0);
        if (g[d] >= 0) begin
          m_data[d] = int'((t_data[d] >> (4 * g[d])) & 16'hF);
          m_ch[d]   = g[d];
          if (t_rr[d]) m_ptr[d] = (g[d] + 1) % nch_of(d);
        end
      end
    end
    #1;
    check_outputs("");
  endtask

  task automatic idle(input int d);
    t_valid[d] = '0; t_data[d] = '0; t_rr[d] = 1'b0; t_sel[d] = 0; t_rdy[d] = 1'b1;
  endtask

  initial begin
    int seq4 [6];
    int seq3 [4];
    seq4 = '{0, 1, 2, 3, 0, 1};
    seq3 = '{0, 1, 2, 0};

    idle(0); idle(1);
    reset = 1'b1;
    model_reset();
    #2;
    check_outputs("_rst");
    @(negedge clock);
    reset = 1'b0;

    // Fixed mode, sel=2 with all channels valid
    t_sel[0] = 2; t_valid[0] = 4'hF; t_data[0] = 16'hDA21;
    #1;
    chk("fix_in_ready", obs(0, 0), 32'h4);
    tick();
    chk("fix_data", obs(0, 2), 32'hA);
    chk("fix_ch", obs(0, 3), 32'd2);
    t_sel[0] = 3; t_valid[0] = 4'h7;
    tick();
    chk("fix_nogrant", obs(0, 1), 32'd0);

    // Round-robin, all valid: 0,1,2,3,0,1 back to back
    t_rr[0] = 1'b1; t_valid[0] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_seq_valid", obs(0, 1), 32'd1);
      chk("rr_seq_ch", obs(0, 3), 32'(seq4[i]));
    end

    // Sparse requests 1001: ch3, ch0, ch3 with wrap
    t_valid[0] = 4'b1001;
    tick(); chk("rr_sparse_a", obs(0, 3), 32'd3);
    tick(); chk("rr_sparse_b", obs(0, 3), 32'd0);
    tick(); chk("rr_sparse_c", obs(0, 3), 32'd3);
    chk("rr_wrap_ptr", obs(0, 4), 32'd0);

    // Backpressure with ch1 waiting, then drain and load together
    t_rdy[0] = 1'b0; t_valid[0] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", obs(0, 2), 32'hD);
      chk("bp_hold_ch", obs(0, 3), 32'd3);
    end
    t_rdy[0] = 1'b1;
    tick();
    chk("bp_reload_ch", obs(0, 3), 32'd1);
    chk("bp_reload_data", obs(0, 2), 32'h2);

    // NCH=3: round-robin order and out-of-range sel
    idle(0);
    t_rr[1] = 1'b1; t_valid[1] = 4'h7; t_data[1] = 16'h0321;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr3_seq_ch", obs(1, 3), 32'(seq3[i]));
    end
    t_rr[1] = 1'b0; t_sel[1] = 3;
    tick();
    tick();
    chk("fix3_nogrant", obs(1, 1), 32'd0);

    // Asynchronous reset while the buffer is full
    t_rr[0] = 1'b1; t_valid[0] = 4'hF; t_data[0] = 16'h9876; t_rdy[0] = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", obs(0, 1), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("_async_rst");
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        t_valid[d] = 4'($urandom) & ((d == 0) ? 4'hF : 4'h7);
        t_data[d]  = 16'($urandom);
        t_rr[d]    = ($urandom_range(0, 3) != 0);
        t_sel[d]   = int'($urandom_range(0, 3));
        t_rdy[d]   = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
